// File: rtl/eth_tx_packet_queue.sv
// Multi-slot transmit packet queue feeding an AXI-Stream MAC port.
// The host fills the tail slot word by word, sets its length and commits it;
// committed slots drain in FIFO order as AXI-Stream frames. A two-entry
// output buffer (RAM output register plus skid register) keeps one beat per
// cycle under steady tready without putting tready on the RAM address path.
//
// Handshake: a beat transfers on a rising edge where tvalid_o && tready_i.
// While tvalid_o is high and tready_i is low, tdata/tkeep/tlast hold their
// values, and tvalid_o never falls before the tlast beat has transferred.

module eth_tx_packet_queue #(
    parameter  int data_width_p  = 32,
    parameter  int eth_mtu_p     = 2048,
    parameter  int slots_p       = 4,
    localparam int bpw_lp        = data_width_p / 8,
    localparam int addr_width_lp = $clog2(eth_mtu_p),
    localparam int size_width_lp = $clog2(eth_mtu_p + 1),
    localparam int cnt_width_lp  = $clog2(slots_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    output logic                     packet_req_o,
    input  logic                     packet_wvalid_i,
    input  logic [addr_width_lp-1:0] packet_waddr_i,
    input  logic [data_width_p-1:0]  packet_wdata_i,
    input  logic                     packet_wsize_valid_i,
    input  logic [size_width_lp-1:0] packet_wsize_i,
    input  logic                     packet_send_i,
    input  logic                     packet_abort_i,
    output logic [data_width_p-1:0]  tx_axis_tdata_o,
    output logic [bpw_lp-1:0]        tx_axis_tkeep_o,
    output logic                     tx_axis_tvalid_o,
    input  logic                     tx_axis_tready_i,
    output logic                     tx_axis_tlast_o,
    output logic                     tx_axis_tuser_o,
    output logic [cnt_width_lp-1:0]  pending_o,
    output logic [15:0]              send_count_o,
    output logic [15:0]              drop_count_o,
    output logic                     dbg_state_o
);

    localparam int off_lp   = $clog2(bpw_lp);
    localparam int waw_lp   = addr_width_lp - off_lp;
    localparam int sw_lp    = $clog2(slots_p);
    localparam int ptr_w_lp = sw_lp + 1;
    localparam int depth_lp = slots_p * (eth_mtu_p / bpw_lp);

    localparam logic [ptr_w_lp-1:0]      full_lp     = ptr_w_lp'(slots_p);
    localparam logic [size_width_lp-1:0] mtu_lp      = size_width_lp'(eth_mtu_p);
    localparam logic [bpw_lp-1:0]        keep_all_lp = '1;

    typedef enum logic {
        IDLE_S   = 1'b0,
        STREAM_S = 1'b1
    } state_e;

    // Storage
    logic [data_width_p-1:0]  mem_q [depth_lp];
    logic [data_width_p-1:0]  ram_rdata_q;
    logic [size_width_lp-1:0] slot_size_q [slots_p];

    // Write side
    logic [ptr_w_lp-1:0]      tail_q;
    logic [size_width_lp-1:0] wsize_q;
    logic [size_width_lp-1:0] wsize_d;
    logic [15:0]              drop_cnt_q;
    logic                     size_ok;
    logic                     commit;
    logic                     drop;
    logic [sw_lp-1:0]         tail_slot;
    logic [sw_lp+waw_lp-1:0]  wr_addr;
    logic                     unused_waddr_lo;

    // Read side
    state_e                   state_q;
    logic [ptr_w_lp-1:0]      head_q;
    logic [ptr_w_lp-1:0]      ptr_diff;
    logic [15:0]              send_cnt_q;
    logic [size_width_lp-1:0] words_q;
    logic [size_width_lp-1:0] rd_idx_q;
    logic [bpw_lp-1:0]        last_keep_q;
    logic                     rv_q;
    logic [bpw_lp-1:0]        r_keep_q;
    logic                     r_last_q;
    logic                     sk_v_q;
    logic [data_width_p-1:0]  sk_data_q;
    logic [bpw_lp-1:0]        sk_keep_q;
    logic                     sk_last_q;

    logic [sw_lp-1:0]         head_slot;
    logic [size_width_lp-1:0] head_size;
    logic [size_width_lp-1:0] head_words;
    logic [off_lp-1:0]        head_rem;
    logic [bpw_lp-1:0]        head_last_keep;
    logic                     start;
    logic                     issue;
    logic                     rd_en;
    logic [waw_lp-1:0]        rd_word;
    logic [sw_lp+waw_lp-1:0]  rd_addr;
    logic                     issue_last;
    logic [bpw_lp-1:0]        issue_keep;
    logic                     hs;
    logic                     frame_done;

    // Occupancy: the extra wrap bit in each pointer separates full from empty
    assign ptr_diff     = tail_q - head_q;
    assign pending_o    = cnt_width_lp'(ptr_diff);
    assign packet_req_o = (ptr_diff < full_lp);

    // Commit decision; a same-cycle size strobe is seen by the send
    assign wsize_d   = packet_wsize_valid_i ? packet_wsize_i : wsize_q;
    assign size_ok   = (wsize_d != '0) && (wsize_d <= mtu_lp);
    assign commit    = packet_send_i && !packet_abort_i && packet_req_o && size_ok;
    assign drop      = packet_send_i && !packet_abort_i && !commit;
    assign tail_slot = tail_q[sw_lp-1:0];
    assign wr_addr   = {tail_slot, packet_waddr_i[addr_width_lp-1:off_lp]};

    // Sub-word address bits carry no information for word writes
    assign unused_waddr_lo = ^packet_waddr_i[off_lp-1:0];

    // Head-slot frame geometry, consumed when a frame starts
    assign head_slot      = head_q[sw_lp-1:0];
    assign head_size      = slot_size_q[head_slot];
    assign head_words     = (head_size + size_width_lp'(bpw_lp - 1)) >> off_lp;
    assign head_rem       = head_size[off_lp-1:0];
    assign head_last_keep = (head_rem == '0) ? keep_all_lp : ~(keep_all_lp << head_rem);

    // RAM reads are issued only when the skid register is empty, so the
    // RAM output register can always be parked in the skid if not taken
    assign start      = (state_q == IDLE_S) && (ptr_diff != '0);
    assign issue      = (state_q == STREAM_S) && !sk_v_q && (rd_idx_q < words_q);
    assign rd_en      = start || issue;
    assign rd_word    = start ? '0 : rd_idx_q[waw_lp-1:0];
    assign rd_addr    = {head_slot, rd_word};
    assign issue_last = start ? (head_words == size_width_lp'(1))
                              : (rd_idx_q == words_q - 1'b1);
    assign issue_keep = issue_last ? (start ? head_last_keep : last_keep_q) : keep_all_lp;

    // Output: the skid entry is always older than the RAM entry
    assign tx_axis_tvalid_o = sk_v_q | rv_q;
    assign tx_axis_tdata_o  = sk_v_q ? sk_data_q : (rv_q ? ram_rdata_q : '0);
    assign tx_axis_tkeep_o  = sk_v_q ? sk_keep_q : (rv_q ? r_keep_q : '0);
    assign tx_axis_tlast_o  = sk_v_q ? sk_last_q : (rv_q && r_last_q);
    assign tx_axis_tuser_o  = 1'b0;
    assign hs               = tx_axis_tvalid_o && tx_axis_tready_i;
    assign frame_done       = hs && tx_axis_tlast_o;

    assign send_count_o = send_cnt_q;
    assign drop_count_o = drop_cnt_q;
    assign dbg_state_o  = state_q;

    // Packet RAM: host writes into the tail slot, synchronous read with enable
    always_ff @(posedge clk_i) begin
        if (packet_wvalid_i && packet_req_o) begin
            mem_q[wr_addr] <= packet_wdata_i;
        end
        if (rd_en) begin
            ram_rdata_q <= mem_q[rd_addr];
        end
    end

    // Write-slot size, slot size table, tail pointer and drop counter
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wsize_q    <= '0;
            tail_q     <= '0;
            drop_cnt_q <= '0;
            for (int i = 0; i < slots_p; i++) begin
                slot_size_q[i] <= '0;
            end
        end else begin
            if (packet_abort_i) begin
                wsize_q <= '0;
            end else if (commit) begin
                slot_size_q[tail_slot] <= wsize_d;
                tail_q                 <= tail_q + 1'b1;
                wsize_q                <= '0;
            end else if (packet_wsize_valid_i) begin
                wsize_q <= packet_wsize_i;
            end
            if (drop) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    // Read FSM with the RAM-output/skid buffer pair and completion accounting
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE_S;
            head_q      <= '0;
            send_cnt_q  <= '0;
            words_q     <= '0;
            rd_idx_q    <= '0;
            last_keep_q <= '0;
            rv_q        <= 1'b0;
            r_keep_q    <= '0;
            r_last_q    <= 1'b0;
            sk_v_q      <= 1'b0;
            sk_data_q   <= '0;
            sk_keep_q   <= '0;
            sk_last_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE_S: begin
                    if (start) begin
                        words_q     <= head_words;
                        last_keep_q <= head_last_keep;
                        rd_idx_q    <= size_width_lp'(1);
                        state_q     <= STREAM_S;
                    end
                end
                STREAM_S: begin
                    if (issue) begin
                        rd_idx_q <= rd_idx_q + 1'b1;
                    end
                    if (frame_done) begin
                        state_q    <= IDLE_S;
                        head_q     <= head_q + 1'b1;
                        send_cnt_q <= send_cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE_S;
            endcase

            // RAM-output entry: refilled on every read, emptied when taken
            if (rd_en) begin
                rv_q     <= 1'b1;
                r_keep_q <= issue_keep;
                r_last_q <= issue_last;
            end else if (hs && !sk_v_q) begin
                rv_q <= 1'b0;
            end

            // Skid entry: catches the RAM entry when a new read would overwrite it
            if (sk_v_q) begin
                if (hs) begin
                    sk_v_q <= 1'b0;
                end
            end else if (rv_q && !hs && rd_en) begin
                sk_v_q    <= 1'b1;
                sk_data_q <= ram_rdata_q;
                sk_keep_q <= r_keep_q;
                sk_last_q <= r_last_q;
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_packet_queue.sv
// Directed testbench for eth_tx_packet_queue with a beat scoreboard.
module tb_eth_tx_packet_queue;

  localparam int DW  = 32;
  localparam int MTU = 2048;
  localparam int BPW = 4;
  localparam int AW  = 11;
  localparam int SW  = 12;
  localparam int CW  = 3;
  localparam int EW  = 1 + BPW + DW;

  logic          clk;
  logic          rst_n;
  logic          packet_req;
  logic          wvalid;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          wsize_valid;
  logic [SW-1:0] wsize;
  logic          send;
  logic          abort;
  logic [DW-1:0] tdata;
  logic [BPW-1:0] tkeep;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic          tuser;
  logic [CW-1:0] pending;
  logic [15:0]   send_count;
  logic [15:0]   drop_count;
  logic          dbg_state;

  int      n_checks = 0;
  int      n_fail = 0;
  longint  cyc = 0;
  logic [EW-1:0] exp_q[$];

  int      beat_idx = 0;
  longint  frame_start = 0;
  int      last_len = 0;
  logic    held_v = 1'b0;
  logic [EW-1:0] held;

  int fill_sz[4] = '{16, 13, 5, 8};

  eth_tx_packet_queue dut (
    .clk_i               (clk),
    .reset_n_i           (rst_n),
    .packet_req_o        (packet_req),
    .packet_wvalid_i     (wvalid),
    .packet_waddr_i      (waddr),
    .packet_wdata_i      (wdata),
    .packet_wsize_valid_i(wsize_valid),
    .packet_wsize_i      (wsize),
    .packet_send_i       (send),
    .packet_abort_i      (abort),
    .tx_axis_tdata_o     (tdata),
    .tx_axis_tkeep_o     (tkeep),
    .tx_axis_tvalid_o    (tvalid),
    .tx_axis_tready_i    (tready),
    .tx_axis_tlast_o     (tlast),
    .tx_axis_tuser_o     (tuser),
    .pending_o           (pending),
    .send_count_o        (send_count),
    .drop_count_o        (drop_count),
    .dbg_state_o         (dbg_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int pid, input int w);
    return {pid[7:0], 8'h5A, w[15:0]};
  endfunction

  function automatic logic [BPW-1:0] last_keep(input int size);
    case (size % 4)
      0:       return 4'hF;
      1:       return 4'h1;
      2:       return 4'h3;
      default: return 4'h7;
    endcase
  endfunction

  task automatic push_expect(input int pid, input int size);
    int words;
    logic lst;
    words = (size + 3) / 4;
    for (int w = 0; w < words; w++) begin
      lst = (w == words - 1);
      exp_q.push_back({lst, (lst ? last_keep(size) : 4'hF), pat(pid, w)});
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_packet(input int pid, input int size);
    int words;
    words = (size + 3) / 4;
    for (int w = 0; w < words; w++) begin
      wvalid = 1'b1;
      waddr  = AW'(w * 4 + (w % 4));
      wdata  = pat(pid, w);
      tick();
    end
    wvalid = 1'b0;
  endtask

  task automatic set_size(input int s);
    wsize_valid = 1'b1;
    wsize       = SW'(s);
    tick();
    wsize_valid = 1'b0;
  endtask

  task automatic do_send();
    send = 1'b1;
    tick();
    send = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_q.size() == 0 && pending == '0 && !tvalid) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check_eq(tag, done, 1'b1);
  endtask

  // Monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    got = {tlast, tkeep, tdata};
    if (!rst_n) begin
      held_v   = 1'b0;
      beat_idx = 0;
    end else begin
      if (held_v) check_eq("stall_hold", {tvalid, got}, {1'b1, held});
      if (tvalid && tready) begin
        check_eq("beat_expected", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("beat", got, e);
        end
        if (beat_idx == 0) frame_start = cyc;
        if (tlast) begin
          last_len = int'(cyc - frame_start + 1);
          beat_idx = 0;
        end else begin
          beat_idx++;
        end
      end
      held_v = tvalid && !tready;
      held   = got;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    logic bp_done;
    rst_n = 1'b0; wvalid = 1'b0; waddr = '0; wdata = '0; wsize_valid = 1'b0;
    wsize = '0; send = 1'b0; abort = 1'b0; tready = 1'b0;
    repeat (3) tick();

    // Reset state
    check_eq("rst_axis", {tvalid, tlast, tkeep, tdata, tuser}, '0);
    check_eq("rst_pending", pending, 0);
    check_eq("rst_req", packet_req, 1);
    check_eq("rst_counts", {send_count, drop_count}, 0);
    check_eq("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    tick();

    // Single 61-byte frame, tready held high
    tready = 1'b1;
    write_packet(1, 61);
    set_size(61);
    push_expect(1, 61);
    do_send();
    check_eq("lat_cycle1_tvalid", tvalid, 0);
    check_eq("pending_after_commit", pending, 1);
    tick();
    check_eq("lat_cycle2_tvalid", tvalid, 1);
    wait_drain("drain_single", 100);
    check_eq("single_len", last_len, 16);
    check_eq("single_send_count", send_count, 1);

    // Fill to full with the sink stalled
    tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      write_packet(10 + i, fill_sz[i]);
      set_size(fill_sz[i]);
      do_send();
      push_expect(10 + i, fill_sz[i]);
    end
    check_eq("full_pending", pending, 4);
    check_eq("full_req", packet_req, 0);
    wvalid = 1'b1; waddr = AW'(12); wdata = 32'hDEADBEEF;
    tick();
    wvalid = 1'b0;
    set_size(8);
    do_send();
    check_eq("full_drop", drop_count, 1);
    check_eq("full_pending_after_drop", pending, 4);
    tready = 1'b1;
    wait_drain("drain_fill", 200);
    check_eq("fill_send_count", send_count, 5);

    // Size rules
    set_size(0);
    do_send();
    check_eq("drop_size0", drop_count, 2);
    set_size(MTU + 1);
    do_send();
    check_eq("drop_oversize", drop_count, 3);
    check_eq("drop_pending", pending, 0);
    set_size(20);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    do_send();
    check_eq("drop_after_abort", drop_count, 4);
    write_packet(20, MTU);
    set_size(MTU);
    push_expect(20, MTU);
    do_send();
    wait_drain("drain_mtu", 1000);
    check_eq("mtu_len", last_len, 512);
    check_eq("mtu_send_count", send_count, 6);

    // Backpressure on a 1500-byte frame
    write_packet(30, 1500);
    set_size(1500);
    push_expect(30, 1500);
    do_send();
    bp_done = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (exp_q.size() == 0 && pending == '0 && !tvalid) begin
        bp_done = 1'b1;
        break;
      end
      tready = 1'($urandom_range(0, 1));
      tick();
    end
    tready = 1'b1;
    check_eq("drain_backpressure", bp_done, 1);
    check_eq("bp_send_count", send_count, 7);

    // Commit on the same edge as a tlast handshake, size strobed with send
    write_packet(40, 14);
    set_size(14);
    push_expect(40, 14);
    do_send();
    write_packet(41, 7);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tvalid && tlast) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_eq("tlast_seen", found, 1);
    wsize_valid = 1'b1; wsize = SW'(7); send = 1'b1;
    push_expect(41, 7);
    tick();
    wsize_valid = 1'b0; send = 1'b0;
    check_eq("same_edge_pending", pending, 1);
    check_eq("same_edge_send_count", send_count, 8);
    check_eq("same_edge_no_drop", drop_count, 4);
    wait_drain("drain_same_edge", 100);
    check_eq("same_edge_total", send_count, 9);

    // Abort and send together: nothing committed, nothing dropped
    set_size(8);
    abort = 1'b1; send = 1'b1;
    tick();
    abort = 1'b0; send = 1'b0;
    check_eq("abort_send_pending", pending, 0);
    check_eq("abort_send_drop", drop_count, 4);
    do_send();
    check_eq("abort_cleared_size", drop_count, 5);

    // Reset during the fifth beat of a frame with another packet queued
    tready = 1'b0;
    write_packet(50, 40);
    set_size(40);
    do_send();
    push_expect(50, 40);
    write_packet(51, 8);
    set_size(8);
    do_send();
    push_expect(51, 8);
    tready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (beat_idx == 4) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_eq("reached_beat5", found, 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_eq("async_rst_axis", {tvalid, tlast, tkeep, tdata}, '0);
    check_eq("async_rst_pending", pending, 0);
    check_eq("async_rst_counts", {send_count, drop_count}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check_eq("post_rst_pending", pending, 0);
    check_eq("post_rst_req", packet_req, 1);
    check_eq("post_rst_tvalid", tvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
